// File: rtl/lane_arbiter_if.sv
// Shared-lane arbiter bus: side requests and completion pulses in, grants and lot status out.
interface lane_arbiter_if;
  logic       ReqIn;
  logic       ReqOut;
  logic       Enter;
  logic       Exit;
  logic       GrantIn;
  logic       GrantOut;
  logic [4:0] Occupancy;
  logic       Full;
  logic       Empty;
  logic       Timeout;

  modport master (
    output ReqIn, ReqOut, Enter, Exit,
    input  GrantIn, GrantOut, Occupancy, Full, Empty, Timeout
  );

  modport slave (
    input  ReqIn, ReqOut, Enter, Exit,
    output GrantIn, GrantOut, Occupancy, Full, Empty, Timeout
  );
endinterface

// File: rtl/lane_arbiter.sv
// Arbitrates a single shared lane between entering and exiting cars and tracks lot occupancy.
// Alternates priority when both sides wait; grants expire after TIMEOUT cycles.
module lane_arbiter #(
  parameter int unsigned CAPACITY     = 16,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned CLEAR_CYCLES = 4
) (
  input logic           Clk,
  input logic           Rst,
  lane_arbiter_if.slave lane
);

  localparam int unsigned CntMax = (TIMEOUT > CLEAR_CYCLES) ? TIMEOUT : CLEAR_CYCLES;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StGrantIn, StGrantOut, StClear} state_e;

  state_e          r_state, w_state_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic [4:0]      r_occ, w_occ_d;
  logic            r_prefer_out, w_prefer_out_d;
  logic            r_grant_in, r_grant_out;
  logic            w_timeout;
  logic            w_full, w_empty, w_elig_in, w_elig_out, w_expired, w_clear_done;

  assign w_full       = (r_occ == 5'(CAPACITY));
  assign w_empty      = (r_occ == 5'd0);
  assign w_elig_in    = lane.ReqIn & ~w_full;
  assign w_elig_out   = lane.ReqOut & ~w_empty;
  assign w_expired    = (r_cnt == CW'(TIMEOUT - 1));
  assign w_clear_done = (r_cnt == CW'(CLEAR_CYCLES - 1));

  // r_cnt is the grant timer in GRANT states and the gap counter in CLEAR; it is zero on entry.
  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt + CW'(1);
    w_occ_d        = r_occ;
    w_prefer_out_d = r_prefer_out;
    w_timeout      = 1'b0;
    case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (w_elig_in && (!w_elig_out || !r_prefer_out)) begin
          w_state_d = StGrantIn;
        end else if (w_elig_out) begin
          w_state_d = StGrantOut;
        end
      end
      StGrantIn: begin
        if (lane.Enter || w_expired) begin
          w_state_d      = StClear;
          w_cnt_d        = '0;
          w_prefer_out_d = 1'b1;
          if (lane.Enter) begin
            if (!w_full) w_occ_d = r_occ + 5'd1;
          end else begin
            w_timeout = 1'b1;
          end
        end
      end
      StGrantOut: begin
        if (lane.Exit || w_expired) begin
          w_state_d      = StClear;
          w_cnt_d        = '0;
          w_prefer_out_d = 1'b0;
          if (lane.Exit) begin
            if (!w_empty) w_occ_d = r_occ - 5'd1;
          end else begin
            w_timeout = 1'b1;
          end
        end
      end
      StClear: begin
        if (w_clear_done) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_occ        <= 5'd0;
      r_prefer_out <= 1'b0;
      r_grant_in   <= 1'b0;
      r_grant_out  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_occ        <= w_occ_d;
      r_prefer_out <= w_prefer_out_d;
      r_grant_in   <= (w_state_d == StGrantIn);
      r_grant_out  <= (w_state_d == StGrantOut);
    end
  end

  assign lane.GrantIn   = r_grant_in;
  assign lane.GrantOut  = r_grant_out;
  assign lane.Occupancy = r_occ;
  assign lane.Full      = w_full;
  assign lane.Empty     = w_empty;
  assign lane.Timeout   = w_timeout;

endmodule

// File: doc/lane_arbiter.md
LANE_ARBITER -- requirements
Module: lane_arbiter

Interface
REQ-001 SHALL have parameter CAPACITY, default 16: maximum lot occupancy.
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum cycles a grant is held without a completion pulse.
REQ-003 SHALL have parameter CLEAR_CYCLES, default 4: cycles both grants stay low between grants.
REQ-004 Clk  input  1  clock; all state updates on posedge Clk.
REQ-005 Rst  input  1  reset, synchronous, active-high.
REQ-006 ReqIn  input  1  level; a car is waiting at the entrance side of the shared lane.
REQ-007 ReqOut  input  1  level; a car is waiting at the exit side of the shared lane.
REQ-008 Enter  input  1  one-cycle pulse from the sensor FSM; a car has completed entry.
REQ-009 Exit  input  1  one-cycle pulse from the sensor FSM; a car has completed exit.
REQ-010 GrantIn  output  1  entrance-side green light; registered.
REQ-011 GrantOut  output  1  exit-side green light; registered.
REQ-012 Occupancy  output  5  current car count, range 0..CAPACITY.
REQ-013 Full  output  1  Occupancy == CAPACITY.
REQ-014 Empty  output  1  Occupancy == 0.
REQ-015 Timeout  output  1  one-cycle pulse when a grant expires without completion.

Function
REQ-016 SHALL implement states IDLE, GRANT_IN, GRANT_OUT, CLEAR.
REQ-017 GrantIn SHALL be 1 only in GRANT_IN; GrantOut SHALL be 1 only in GRANT_OUT; the two are never both 1.
REQ-018 An entry request is eligible iff ReqIn=1 and Full=0; an exit request is eligible iff ReqOut=1 and Empty=0.
REQ-019 In IDLE with exactly one eligible request: next state is the matching GRANT state; the grant output is high in the cycle after the request is sampled (1-cycle latency).
REQ-020 In IDLE with both requests eligible: grant the side indicated by priority flag PreferOut (0 = entry, 1 = exit).
REQ-021 In IDLE with no eligible request: remain in IDLE.
REQ-022 PreferOut SHALL be set to 1 on leaving GRANT_IN and cleared to 0 on leaving GRANT_OUT (alternating fairness).
REQ-023 In GRANT_IN, an Enter pulse SHALL increment Occupancy by 1, saturating at CAPACITY, and move to CLEAR on the next edge.
REQ-024 In GRANT_OUT, an Exit pulse SHALL decrement Occupancy by 1, saturating at 0, and move to CLEAR on the next edge.
REQ-025 A grant SHALL be held after its request deasserts, until the completion pulse or timeout.
REQ-026 The grant timer SHALL clear on grant entry and count cycles spent in the GRANT state; when it reaches TIMEOUT-1 with no completion pulse, Timeout SHALL pulse for that one cycle, Occupancy SHALL be unchanged, and the state SHALL move to CLEAR.
REQ-027 A completion pulse arriving in the same cycle as timer expiry SHALL count as completion; Timeout stays 0.
REQ-028 Enter outside GRANT_IN and Exit outside GRANT_OUT SHALL be ignored (Occupancy unchanged).
REQ-029 Enter and Exit together in a GRANT state: only the pulse matching the granted side is applied.
REQ-030 CLEAR SHALL last exactly CLEAR_CYCLES cycles with both grants 0, then return to IDLE.
REQ-031 Full and Empty SHALL be derived combinationally from the Occupancy register.

Reset
REQ-032 While Rst=1 at a clock edge: state=IDLE, Occupancy=0, PreferOut=0, timer=0, GrantIn=0, GrantOut=0, Timeout=0.
REQ-033 Rst asserted mid-grant SHALL abort the grant and discard any same-cycle Enter or Exit pulse.

Verification
REQ-034 Reset, then ReqIn=1 for 1 cycle, then Enter pulse 3 cycles later -> GrantIn=1 from cycle +1 until the Enter edge; Occupancy 0->1; grants 0 for 4 cycles afterward.
REQ-035 Occupancy=2, PreferOut=0, ReqIn and ReqOut held high -> grant order In, Out, In, Out; each Enter/Exit pulse applied; Occupancy alternates 3, 2, 3, 2.
REQ-036 Occupancy=16, ReqIn=1 -> no GrantIn, Full=1; ReqOut=1 added -> GrantOut granted; after Exit, Occupancy=15 and Full=0.
REQ-037 Reset, ReqOut=1 -> no grant while Empty=1.
REQ-038 GRANT_IN with no Enter for 64 cycles -> Timeout=1 for one cycle, Occupancy unchanged, CLEAR entered, PreferOut=1.
REQ-039 Rst pulsed during GRANT_OUT coincident with Exit -> grants 0 and Occupancy=0 on the next cycle, Exit not applied.
